// File: rtl/rollback_walker.sv
// rollback_walker: after a mispredict/exception flush, walks the ROB from the
// youngest entry back toward the flushing instruction. It presents up to two
// squashed entries per cycle on the rename rollback ports (slot 0 = younger,
// slot 1 = older). It then pulses done together with the new ROB tail.
module rollback_walker #(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_req,
    input  logic [IDX_W-1:0] flush_idx,
    input  logic [IDX_W-1:0] rob_tail,
    output logic [IDX_W-1:0] rob_raddr_0,
    output logic [IDX_W-1:0] rob_raddr_1,
    input  logic [5:0]       rob_A_rd_0,
    input  logic [5:0]       rob_A_rd_1,
    input  logic [6:0]       rob_P_rd_old_0,
    input  logic [6:0]       rob_P_rd_old_1,
    input  logic [6:0]       rob_P_rd_new_0,
    input  logic [6:0]       rob_P_rd_new_1,
    output logic             rollback_en_0,
    output logic             rollback_en_1,
    output logic [5:0]       rollback_A_rd_0,
    output logic [5:0]       rollback_A_rd_1,
    output logic [6:0]       rollback_P_rd_old_0,
    output logic [6:0]       rollback_P_rd_old_1,
    output logic [6:0]       rollback_P_rd_new_0,
    output logic [6:0]       rollback_P_rd_new_1,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] new_tail
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   remain_q, remain_d;
    logic [IDX_W-1:0] tail_q, tail_d;

    // Squash count; IDX_W-bit wrap makes rob_tail==flush_idx a full ROB (DEPTH-1).
    logic [IDX_W-1:0] squash_cnt_s;
    logic [IDX_W-1:0] ptr_m1_s;
    logic             walk_s;
    logic             pair_s;

    assign squash_cnt_s = rob_tail - flush_idx - IDX_W'(1);
    assign ptr_m1_s     = ptr_q - IDX_W'(1);
    assign walk_s       = (state_q == ST_WALK);
    assign pair_s       = (remain_q >= (IDX_W+1)'(2));

    // State register with asynchronous reset; a reset mid-walk aborts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= {IDX_W{1'b0}};
            remain_q <= {(IDX_W+1){1'b0}};
            tail_q   <= {IDX_W{1'b0}};
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            remain_q <= remain_d;
            tail_q   <= tail_d;
        end
    end

    // Next-state logic: start on flush, consume two entries per WALK cycle.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        remain_d = remain_q;
        tail_d   = tail_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    tail_d = flush_idx + IDX_W'(1);
                    if (squash_cnt_s == {IDX_W{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d    = rob_tail - IDX_W'(1);
                        remain_d = {1'b0, squash_cnt_s};
                        state_d  = ST_WALK;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WALK: begin
                if (pair_s) begin
                    ptr_d    = ptr_q - IDX_W'(2);
                    remain_d = remain_q - (IDX_W+1)'(2);
                    if (remain_q == (IDX_W+1)'(2)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WALK;
                    end
                end else begin
                    remain_d = {(IDX_W+1){1'b0}};
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state; slot 1 always carries the older entry.
    always_comb begin
        rob_raddr_0   = walk_s ? ptr_q : {IDX_W{1'b0}};
        rob_raddr_1   = walk_s ? ptr_m1_s : {IDX_W{1'b0}};
        rollback_en_0 = walk_s;
        rollback_en_1 = walk_s && pair_s;
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
        new_tail      = (state_q == ST_DONE) ? tail_q : {IDX_W{1'b0}};
    end

    // ROB read data passes straight through to the rename rollback ports.
    always_comb begin
        rollback_A_rd_0     = rob_A_rd_0;
        rollback_A_rd_1     = rob_A_rd_1;
        rollback_P_rd_old_0 = rob_P_rd_old_0;
        rollback_P_rd_old_1 = rob_P_rd_old_1;
        rollback_P_rd_new_0 = rob_P_rd_new_0;
        rollback_P_rd_new_1 = rob_P_rd_new_1;
    end

endmodule
